// File: rtl/serial_to_parallel_pkg.sv
// ============================================================================
// serial_to_parallel_pkg : shared state encoding and word-geometry helper
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package serial_to_parallel_pkg;

  typedef enum logic {
    S2P_COLLECT = 1'b0,
    S2P_FULL    = 1'b1
  } s2p_state_e;

  function automatic int bytes_per_word(input int n);
    return n / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/s2p_gap_timer.sv
// ============================================================================
// s2p_gap_timer : inter-byte gap counter with single-cycle expiry indication
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module s2p_gap_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int GW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] LAST = GW'(TIMEOUT - 1);

  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;

  // An arriving byte beats a coincident expiry.
  assign expire_o = run_i && !clear_i && (gap_q == LAST);

  always_comb begin
    gap_d = gap_q + 1'b1;
    if (!run_i || clear_i || expire_o) begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_to_parallel.sv
// ============================================================================
// serial_to_parallel : little-endian byte-to-word assembler, valid/ready out
// Optional inter-byte timeout enabled by macro S2P_TIMEOUT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int N       = 32,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic         iCE_CLK,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  input  logic         word_ready,
  output logic [N-1:0] word,
  output logic         word_valid,
  output logic         overrun,
  output logic         timeout_err
);

  localparam int BYTES_PER_WORD = bytes_per_word(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD);

  s2p_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     word_q, word_d;
  logic             overrun_q, overrun_d;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] wr_cnt;
  logic             gap_expire;

`ifdef S2P_TIMEOUT_EN
  logic gap_run;
  logic timeout_err_q;

  assign gap_run = (state_q == S2P_COLLECT) && (cnt_q != '0);

  s2p_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk      (iCE_CLK),
    .rst_n    (rst_n),
    .run_i    (gap_run),
    .clear_i  (rx_valid),
    .expire_o (gap_expire)
  );

  always_ff @(posedge iCE_CLK) begin
    if (!rst_n) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= gap_expire;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign gap_expire  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign wr_cnt = wr_idx + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    wr_idx    = cnt_q;

    if (state_q == S2P_COLLECT) begin
      if (rx_valid) begin
        wr_en = 1'b1;
      end else if (gap_expire) begin
        cnt_d = '0;
      end
    end else begin
      if (word_ready) begin
        cnt_d   = '0;
        state_d = S2P_COLLECT;
        // A byte arriving on the handshake edge starts the next word.
        if (rx_valid) begin
          wr_en  = 1'b1;
          wr_idx = '0;
        end
      end else if (rx_valid) begin
        overrun_d = 1'b1;
      end
    end

    if (wr_en) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (wr_idx == CNT_W'(b)) begin
          word_d[8*b +: 8] = rx_byte;
        end
      end
      cnt_d   = wr_cnt;
      state_d = (wr_cnt == LAST_CNT) ? S2P_FULL : S2P_COLLECT;
    end
  end

  always_ff @(posedge iCE_CLK) begin
    if (!rst_n) begin
      state_q   <= S2P_COLLECT;
      cnt_q     <= '0;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      overrun_q <= overrun_d;
    end
  end

  assign word       = word_q;
  assign word_valid = (state_q == S2P_FULL);
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
// ============================================================================
// tb_serial_to_parallel : directed plus randomized checks against a byte-queue
// reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_to_parallel;

  localparam int N   = 32;
  localparam int BPW = N / 8;
`ifdef S2P_TIMEOUT_EN
  localparam int TIMEOUT_P = 16;
  localparam bit TO_EN     = 1'b1;
`else
  localparam int TIMEOUT_P = 1_000_000;
  localparam bit TO_EN     = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         word_ready = 1'b0;
  logic [N-1:0] word;
  logic         word_valid;
  logic         overrun;
  logic         timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  serial_to_parallel #(
    .N       (N),
    .CNT_W   (3),
    .TIMEOUT (TIMEOUT_P)
  ) dut (
    .iCE_CLK     (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .word_ready  (word_ready),
    .word        (word),
    .word_valid  (word_valid),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the word, how many of the current word have
  // arrived, whether a word is held, and idle cycles since the last byte.
  logic [7:0] m_bytes [BPW];
  int         m_cnt   = 0;
  bit         m_valid = 1'b0;
  bit         m_over  = 1'b0;
  bit         m_terr  = 1'b0;
  int         m_idle  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_word();
    logic [N-1:0] w;
    for (int b = 0; b < BPW; b++) w[8*b +: 8] = m_bytes[b];
    return w;
  endfunction

  always @(posedge clk) begin
    bit take;
    if (!rst_n) begin
      m_cnt = 0; m_valid = 0; m_over = 0; m_terr = 0; m_idle = 0;
      for (int b = 0; b < BPW; b++) m_bytes[b] = 8'h00;
    end else begin
      m_terr = 0;
      take   = 0;
      if (m_valid) begin
        if (word_ready) begin
          m_valid = 0;
          m_cnt   = 0;
          take    = rx_valid;
        end else if (rx_valid) begin
          m_over = 1;
        end
      end else begin
        take = rx_valid;
      end
      if (take) begin
        m_bytes[m_cnt] = rx_byte;
        m_cnt++;
        m_idle = 0;
        if (m_cnt == BPW) m_valid = 1;
      end else if (TO_EN && !m_valid && m_cnt > 0) begin
        m_idle++;
        if (m_idle == TIMEOUT_P) begin
          m_cnt  = 0;
          m_idle = 0;
          m_terr = 1;
        end
      end
    end
    #1;
    check("word_valid", 64'(word_valid), 64'(m_valid));
    check("overrun", 64'(overrun), 64'(m_over));
    check("timeout_err", 64'(timeout_err), 64'(m_terr));
    if (m_valid) check("word", 64'(word), 64'(model_word()));
  end

  task automatic tick(input bit rv, input logic [7:0] b, input bit rdy, input bit rstn);
    @(negedge clk);
    rx_valid   = rv;
    rx_byte    = b;
    word_ready = rdy;
    rst_n      = rstn;
    @(posedge clk);
    #2;
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tick(1'b1, w[8*i +: 8], 1'b0, 1'b1);
  endtask

  initial begin
    #300_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 0);
    check("rst_word", 64'(word), 64'h0);
    check("rst_valid", 64'(word_valid), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    check("rst_terr", 64'(timeout_err), 64'h0);

    send4(32'hDDCCBBAA);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(word_valid), 64'h1);
      check("hold_word", 64'(word), 64'hDDCCBBAA);
      tick(0, 8'h00, 0, 1);
    end

    tick(1, 8'hEE, 0, 1);
    check("ovr_flag", 64'(overrun), 64'h1);
    check("ovr_word", 64'(word), 64'hDDCCBBAA);

    tick(0, 8'h00, 1, 1);
    check("hs_valid", 64'(word_valid), 64'h0);
    send4(32'h44332211);
    check("w2_word", 64'(word), 64'h44332211);

    tick(1, 8'h55, 1, 1);
    check("sim_valid", 64'(word_valid), 64'h0);
    check("sim_byte0", 64'(word[7:0]), 64'h55);
    tick(1, 8'h66, 0, 1);
    tick(1, 8'h77, 0, 1);
    tick(1, 8'h88, 0, 1);
    check("sim_word", 64'(word), 64'h88776655);

    tick(0, 8'h00, 1, 1);
    tick(1, 8'hAA, 0, 1);
    tick(1, 8'hBB, 0, 1);
    tick(0, 8'h00, 0, 0);
    check("mid_rst_ovr", 64'(overrun), 64'h0);
    send4(32'h04030201);
    check("mid_rst_word", 64'(word), 64'h04030201);
    check("mid_rst_ovr2", 64'(overrun), 64'h0);

    tick(0, 8'h00, 1, 1);
    tick(1, 8'hAA, 0, 1);
`ifdef S2P_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick(0, 8'h00, 0, 1);
    check("to_before", 64'(timeout_err), 64'h0);
    tick(0, 8'h00, 0, 1);
    check("to_pulse", 64'(timeout_err), 64'h1);
    tick(0, 8'h00, 0, 1);
    check("to_after", 64'(timeout_err), 64'h0);
    send4(32'h04030201);
    check("to_word", 64'(word), 64'h04030201);
`else
    for (int i = 0; i < 20; i++) tick(0, 8'h00, 0, 1);
    tick(1, 8'h01, 0, 1);
    tick(1, 8'h02, 0, 1);
    tick(1, 8'h03, 0, 1);
    check("stale_word", 64'(word), 64'h030201AA);
`endif

    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0,
           ($urandom % 200) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
